// File: rtl/tx_rd_req_arb.sv
// Read-request arbiter: merges new DMA chunk reads and timeout retries onto the TX
// read-TLP generator and owns the read-tag pool. Grant statistics under TX_RD_ARB_STATS_EN.
module tx_rd_req_arb #(
  parameter int NUM_TAGS     = 4,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic             rd_req,
  input  logic [63:0]      rd_addr,
  input  logic [8:0]       rd_qwords,
  output logic             rd_req_ack,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             retry_req,
  input  logic [63:0]      retry_addr,
  input  logic [9:0]       retry_dwords,
  input  logic [TAG_W-1:0] retry_tag,
  output logic             retry_req_ack,
  output logic             gen_req,
  output logic [63:0]      gen_addr,
  output logic [9:0]       gen_dwords,
  output logic [TAG_W-1:0] gen_tag,
  input  logic             gen_ack,
  input  logic             tag_release,
  input  logic [TAG_W-1:0] tag_release_id,
  output logic [4:0]       tags_free,
  output logic [15:0]      stat_retries,
  output logic [15:0]      stat_new
);

  // Handshake: each source holds req and its data stable until it sees its one-cycle
  // ack; the generator sees gen_req with stable data until it pulses gen_ack once.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [NUM_TAGS-1:0] busy_q;
  logic [NUM_TAGS-1:0] busy_nxt;
  logic [4:0]          free_nxt;
  logic [TAG_W-1:0]    free_idx;
  logic                any_free;
  logic                new_ok;
  logic                take_retry;
  logic                take_new;
  logic                win_new_q;
  logic [7:0]          starve_cnt;

  // Lowest-index free tag; the descending scan leaves the smallest hit in place.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = TAG_W'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    new_ok     = rd_req && any_free;
    take_retry = 1'b0;
    take_new   = 1'b0;
    if (state == ST_IDLE) begin
      if (retry_req && new_ok) begin
        if (starve_cnt == 8'(STARVE_LIMIT)) take_new = 1'b1;
        else                                take_retry = 1'b1;
      end else if (retry_req) begin
        take_retry = 1'b1;
      end else if (new_ok) begin
        take_new = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take_retry || take_new) state_nxt = ST_ISSUE;
      ST_ISSUE: if (gen_ack) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    gen_req       = (state == ST_ISSUE);
    rd_req_ack    = (state == ST_GAP) && win_new_q;
    retry_req_ack = (state == ST_GAP) && !win_new_q;
    rd_tag        = rd_req_ack ? gen_tag : '0;
  end

  // Release and allocation may coincide; they never name the same tag because the
  // tag being allocated is still free until this edge.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (tag_release && int'(tag_release_id) == i) busy_nxt[i] = 1'b0;
      if ((state == ST_ISSUE) && gen_ack && win_new_q && int'(gen_tag) == i)
        busy_nxt[i] = 1'b1;
    end
    free_nxt = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      free_nxt = free_nxt + 5'(!busy_nxt[i]);
    end
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      tags_free  <= 5'(NUM_TAGS);
      starve_cnt <= '0;
      win_new_q  <= 1'b0;
      gen_addr   <= '0;
      gen_dwords <= '0;
      gen_tag    <= '0;
    end else begin
      busy_q    <= busy_nxt;
      tags_free <= free_nxt;
      if (take_retry) begin
        win_new_q  <= 1'b0;
        gen_addr   <= retry_addr;
        gen_dwords <= retry_dwords;
        gen_tag    <= retry_tag;
        starve_cnt <= new_ok ? starve_cnt + 8'd1 : 8'd0;
      end else if (take_new) begin
        win_new_q  <= 1'b1;
        gen_addr   <= rd_addr;
        gen_dwords <= {rd_qwords, 1'b0};
        gen_tag    <= free_idx;
        starve_cnt <= 8'd0;
      end
    end
  end

`ifdef TX_RD_ARB_STATS_EN
  // Counted on the ack pulse so an aborted (reset) transaction is never counted.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      stat_retries <= '0;
      stat_new     <= '0;
    end else begin
      if (retry_req_ack && stat_retries != 16'hFFFF) stat_retries <= stat_retries + 16'd1;
      if (rd_req_ack && stat_new != 16'hFFFF)        stat_new     <= stat_new + 16'd1;
    end
  end
`else
  assign stat_retries = '0;
  assign stat_new     = '0;
`endif

`ifndef SYNTHESIS
  a_ack_onehot: assert property (@(posedge trn_clk) disable iff (reset)
    !(rd_req_ack && retry_req_ack));
  a_gen_hold: assert property (@(posedge trn_clk) disable iff (reset)
    gen_req && !gen_ack |=> gen_req && $stable(gen_addr) && $stable(gen_dwords) && $stable(gen_tag));
  a_starve_bound: assert property (@(posedge trn_clk) disable iff (reset)
    starve_cnt <= 8'(STARVE_LIMIT));
  a_free_bound: assert property (@(posedge trn_clk) disable iff (reset)
    tags_free <= 5'(NUM_TAGS));
`endif

endmodule

// File: tb/tb_tx_rd_req_arb.sv
// Randomized bench for tx_rd_req_arb: a transaction-level model (tag set, starvation
// count, grant counters) predicts every grant, ack pulse and free-tag count.
module tb_tx_rd_req_arb;
  localparam int NUM_TAGS     = 4;
  localparam int TAG_W        = 4;
  localparam int STARVE_LIMIT = 8;

  logic             trn_clk = 1'b0;
  logic             reset;
  logic             rd_req;
  logic [63:0]      rd_addr;
  logic [8:0]       rd_qwords;
  logic             rd_req_ack;
  logic [TAG_W-1:0] rd_tag;
  logic             retry_req;
  logic [63:0]      retry_addr;
  logic [9:0]       retry_dwords;
  logic [TAG_W-1:0] retry_tag;
  logic             retry_req_ack;
  logic             gen_req;
  logic [63:0]      gen_addr;
  logic [9:0]       gen_dwords;
  logic [TAG_W-1:0] gen_tag;
  logic             gen_ack;
  logic             tag_release;
  logic [TAG_W-1:0] tag_release_id;
  logic [4:0]       tags_free;
  logic [15:0]      stat_retries;
  logic [15:0]      stat_new;

  tx_rd_req_arb #(
    .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .trn_clk(trn_clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_qwords(rd_qwords),
    .rd_req_ack(rd_req_ack), .rd_tag(rd_tag),
    .retry_req(retry_req), .retry_addr(retry_addr), .retry_dwords(retry_dwords),
    .retry_tag(retry_tag), .retry_req_ack(retry_req_ack),
    .gen_req(gen_req), .gen_addr(gen_addr), .gen_dwords(gen_dwords), .gen_tag(gen_tag),
    .gen_ack(gen_ack), .tag_release(tag_release), .tag_release_id(tag_release_id),
    .tags_free(tags_free), .stat_retries(stat_retries), .stat_new(stat_new)
  );

  // clock / reset
  always #5 trn_clk = ~trn_clk;

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [77:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model
  bit m_busy[NUM_TAGS];
  int m_starve;
  int m_stat_new;
  int m_stat_ret;

  task automatic m_reset();
    for (int i = 0; i < NUM_TAGS; i++) m_busy[i] = 1'b0;
    m_starve   = 0;
    m_stat_new = 0;
    m_stat_ret = 0;
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < NUM_TAGS; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NUM_TAGS; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  function automatic int pick_busy();
    int c[$];
    for (int i = 0; i < NUM_TAGS; i++) if (m_busy[i]) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic int pick_rel();
    int id = pick_busy();
    if (id < 0 || $urandom_range(0, 1) == 0) id = $urandom_range(0, 15);
    return id;
  endfunction

  task automatic m_release(input int id);
    if (id >= 0 && id < NUM_TAGS) m_busy[id] = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef TX_RD_ARB_STATS_EN
    check({tag, "_stat_new"}, 64'(stat_new), 64'(m_stat_new));
    check({tag, "_stat_ret"}, 64'(stat_retries), 64'(m_stat_ret));
`else
    check({tag, "_stat_new"}, 64'(stat_new), 64'd0);
    check({tag, "_stat_ret"}, 64'(stat_retries), 64'd0);
`endif
  endtask

  // drivers
  task automatic drive_release(input int id);
    tag_release    = 1'b1;
    tag_release_id = TAG_W'(id);
  endtask

  task automatic check_gen(input string tag, input logic [77:0] e);
    check({tag, "_addr"}, gen_addr, e[63:0]);
    check({tag, "_dwords"}, 64'(gen_dwords), 64'(e[73:64]));
    check({tag, "_tag"}, 64'(gen_tag), 64'(e[77:74]));
  endtask

  // One arbitration opportunity: optionally raise requests, then either an idle cycle
  // or a full grant (IDLE -> ISSUE -> GAP) checked against the model.
  task automatic round(input int p_new, input int p_retry, input int p_rel);
    bit               new_ok;
    bit               win_new;
    int               rid;
    int               d;
    logic [63:0]      e_addr;
    logic [9:0]       e_dw;
    logic [TAG_W-1:0] e_tag;
    logic [77:0]      e;
    if (!rd_req && $urandom_range(0, 99) < p_new) begin
      rd_req    = 1'b1;
      rd_addr   = {$urandom(), $urandom()};
      rd_qwords = 9'($urandom_range(0, 511));
    end
    if (!retry_req && $urandom_range(0, 99) < p_retry) begin
      retry_req    = 1'b1;
      retry_addr   = {$urandom(), $urandom()};
      retry_dwords = 10'($urandom_range(0, 1023));
      retry_tag    = TAG_W'($urandom_range(0, NUM_TAGS - 1));
    end
    new_ok = rd_req && (m_free() > 0);
    if (!retry_req && !new_ok) begin
      if (rd_req) begin
        step();
        check("exhaust_no_gen", 64'(gen_req), 64'd0);
        check("exhaust_free", 64'(tags_free), 64'd0);
        rid = pick_busy();
      end else begin
        rid = ($urandom_range(0, 99) < p_rel) ? $urandom_range(0, 15) : -1;
      end
      if (rid >= 0) drive_release(rid);
      step();
      tag_release = 1'b0;
      m_release(rid);
      if (!rd_req) check("idle_gen_req", 64'(gen_req), 64'd0);
      check("idle_tags_free", 64'(tags_free), 64'(m_free()));
      return;
    end

    if (retry_req && new_ok) win_new = (m_starve == STARVE_LIMIT);
    else                     win_new = !retry_req;
    if (win_new) begin
      m_starve = 0;
      e_addr   = rd_addr;
      e_dw     = 10'(rd_qwords) * 10'd2;
      e_tag    = TAG_W'(m_lowest());
    end else begin
      m_starve = new_ok ? m_starve + 1 : 0;
      e_addr   = retry_addr;
      e_dw     = retry_dwords;
      e_tag    = retry_tag;
    end
    exp_q.push_back({e_tag, e_dw, e_addr});

    step();
    check("gen_req_rise", 64'(gen_req), 64'd1);
    e = exp_q.pop_front();
    d = $urandom_range(0, 3);
    for (int k = 0; k < d; k++) begin
      check_gen("issue", e);
      rid = ($urandom_range(0, 99) < p_rel) ? pick_rel() : -1;
      if (rid >= 0) drive_release(rid);
      step();
      tag_release = 1'b0;
      m_release(rid);
      check("issue_hold", 64'(gen_req), 64'd1);
      check("issue_free", 64'(tags_free), 64'(m_free()));
    end
    check_gen("issue", e);

    gen_ack = 1'b1;
    rid = ($urandom_range(0, 99) < p_rel) ? pick_rel() : -1;
    if (rid >= 0) drive_release(rid);
    step();
    gen_ack     = 1'b0;
    tag_release = 1'b0;
    m_release(rid);
    if (win_new) m_busy[int'(e[77:74])] = 1'b1;
    check("gap_gen_req", 64'(gen_req), 64'd0);
    check("gap_rd_ack", 64'(rd_req_ack), 64'(win_new));
    check("gap_retry_ack", 64'(retry_req_ack), 64'(!win_new));
    check("gap_rd_tag", 64'(rd_tag), win_new ? 64'(e[77:74]) : 64'd0);
    check("gap_tags_free", 64'(tags_free), 64'(m_free()));
    check_stats("gap");
    if (win_new) begin
      m_stat_new++;
      rd_req = 1'b0;
    end else begin
      m_stat_ret++;
      retry_req = 1'b0;
    end
    step();
    check("post_rd_ack", 64'(rd_req_ack), 64'd0);
    check("post_retry_ack", 64'(retry_req_ack), 64'd0);
    check_stats("post");
  endtask

  initial begin
    reset = 1'b1;
    rd_req = 1'b0; rd_addr = '0; rd_qwords = '0;
    retry_req = 1'b0; retry_addr = '0; retry_dwords = '0; retry_tag = '0;
    gen_ack = 1'b0; tag_release = 1'b0; tag_release_id = '0;
    m_reset();
    repeat (3) step();
    check("rst_gen_req", 64'(gen_req), 64'd0);
    check("rst_rd_ack", 64'(rd_req_ack), 64'd0);
    check("rst_retry_ack", 64'(retry_req_ack), 64'd0);
    check("rst_rd_tag", 64'(rd_tag), 64'd0);
    check("rst_gen_addr", gen_addr, 64'd0);
    check("rst_gen_dwords", 64'(gen_dwords), 64'd0);
    check("rst_gen_tag", 64'(gen_tag), 64'd0);
    check("rst_tags_free", 64'(tags_free), 64'(NUM_TAGS));
    check_stats("rst");
    reset = 1'b0;
    step();

    // single new read: 16 qwords -> 32 dwords, tag 0
    rd_req = 1'b1; rd_addr = 64'h1000_0000; rd_qwords = 9'd16;
    round(0, 0, 0);

    // simultaneous requests: retry first, then the new read
    rd_req = 1'b1; rd_addr = 64'h2000_0040; rd_qwords = 9'd5;
    retry_req = 1'b1; retry_addr = 64'h3000_0080; retry_dwords = 10'd64; retry_tag = 4'd1;
    round(0, 0, 0);
    round(0, 0, 0);

    // tag exhaustion, then releases (including free and out-of-range ids)
    repeat (10) round(100, 0, 0);
    repeat (12) round(0, 0, 100);

    // continuous retries competing with new reads
    repeat (80) round(100, 100, 30);

    // mixed traffic
    repeat (300) round(50, 50, 30);

    // reset in the middle of an issued request
    rd_req = 1'b0;
    retry_req = 1'b1; retry_addr = {$urandom(), $urandom()}; retry_dwords = 10'd8; retry_tag = 4'd0;
    step();
    check("mid_gen_req", 64'(gen_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_gen_req", 64'(gen_req), 64'd0);
    check("mid_rst_tags_free", 64'(tags_free), 64'(NUM_TAGS));
    check("mid_rst_retry_ack", 64'(retry_req_ack), 64'd0);
    check("mid_rst_stat_new", 64'(stat_new), 64'd0);
    check("mid_rst_stat_ret", 64'(stat_retries), 64'd0);
    retry_req = 1'b0;
    m_reset();
    step();
    check("mid_rst_no_ack", 64'(retry_req_ack | rd_req_ack), 64'd0);
    reset = 1'b0;
    step();
    check("after_rst_gen_req", 64'(gen_req), 64'd0);
    check("after_rst_tags_free", 64'(tags_free), 64'(NUM_TAGS));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_rd_req_arb.md
Name: tx_rd_req_arb

Overview:
- Arbitrates two memory-read request sources onto the single TX memory-read TLP generator.
  - New chunk reads from the RX DMA engine.
  - Timeout retries from the retry monitor.
- Owns the read-tag pool: allocates tags to new reads and frees them on final completion.
- Sits between the DMA chunk logic / retry monitor and the TX TLP engine, in the trn_clk domain.

Parameters:
- NUM_TAGS, 4, number of outstanding read tags; legal 2..16.
- TAG_W, 4, width of tag fields.
- STARVE_LIMIT, 8, max consecutive retry grants while a grantable new read waits; legal 1..255.

Ports:
- trn_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  new read request; held with data stable until rd_req_ack.
- rd_addr  in  64  host address of new read.
- rd_qwords  in  9  length in qwords.
- rd_req_ack  out  1  one-cycle grant pulse to new-read source.
- rd_tag  out  TAG_W  tag allocated; valid in the rd_req_ack cycle.
- retry_req  in  1  retry request; held with data stable until retry_req_ack.
- retry_addr  in  64  retry address.
- retry_dwords  in  10  retry length in dwords.
- retry_tag  in  TAG_W  tag being retried (already allocated).
- retry_req_ack  out  1  one-cycle grant pulse to retry source.
- gen_req  out  1  request to TLP generator.
- gen_addr  out  64  address to generator.
- gen_dwords  out  10  length in dwords.
- gen_tag  out  TAG_W  tag to generator.
- gen_ack  in  1  generator accepted the request (single-cycle pulse).
- tag_release  in  1  final completion received for tag_release_id.
- tag_release_id  in  TAG_W  tag to free.
- tags_free  out  5  count of free tags.
- stat_retries  out  16  retry grant count (see Optional Feature).
- stat_new  out  16  new-read grant count (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high) clears all state; every output is 0 except tags_free = NUM_TAGS.
- Tag busy vector, NUM_TAGS bits; tags_free is its popcount, registered.
- A new read is grantable when rd_req=1 and at least one tag is free. The allocated tag is the lowest-index free tag.
- Retry is grantable whenever retry_req=1. A retry never changes the busy vector.

FSM states:
- IDLE
  - Both grantable: retry wins unless starve_cnt == STARVE_LIMIT, then new wins.
  - On winning, latch gen_addr/gen_dwords/gen_tag and assert gen_req next cycle -> ISSUE.
  - New-read length: gen_dwords = {rd_qwords,1'b0}; rd_qwords=0 is forwarded as 0 dwords, no checking.
- ISSUE
  - gen_req held high with stable data until gen_ack.
  - On gen_ack: gen_req=0; pulse the winner's ack for exactly one cycle; for a new read, drive rd_tag and set its busy bit. -> GAP.
- GAP
  - One idle cycle so the source can drop its req. -> IDLE.
  - Request-to-gen_req latency is 1 cycle from IDLE; minimum 3 cycles between grants.

Starvation counter:
- starve_cnt increments on each retry grant made while a new read was also grantable.
- It resets to 0 on a new-read grant, or on a retry grant with no grantable new read.

tag_release:
- Clears the busy bit the same cycle.
- Release of a non-busy tag, or of an id >= NUM_TAGS, is ignored.
- If release and allocation land in the same cycle, both apply; they cannot target the same tag.
- Releasing a tag whose retry is in flight is legal; the bit clears and the tag may be reallocated.

Other rules:
- Dropping a req before its ack is a protocol violation; the FSM still completes the latched transaction.
- Reset mid-transaction: gen_req drops immediately; no ack pulse is issued; all tags return to free.

Optional Feature:
- Macro TX_RD_ARB_STATS_EN.
- Defined:
  - stat_retries and stat_new count retry and new-read grants, incrementing on the ack pulse.
  - Both are 16-bit saturating at 0xFFFF and cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Single new read: rd_req, rd_addr=0x1000_0000, rd_qwords=16, gen_ack 2 cycles after gen_req -> gen_dwords=32, gen_tag=0, rd_req_ack pulse with rd_tag=0, tags_free 4->3.
- Tag exhaustion: 4 new reads granted (tags 0,1,2,3), then a 5th rd_req -> no gen_req, tags_free=0. After tag_release_id=2 -> 5th granted with tag 2.
- Priority: rd_req and retry_req (tag=1, dwords=64) raised same cycle -> retry issued first (gen_tag=1, gen_dwords=64, busy vector unchanged), then new read.
- Starvation: retry_req held continuously with rd_req and a free tag, STARVE_LIMIT=8 -> 8 retry grants, then new-read grant, then retries resume.
- Release of free tag 3 -> ignored, tags_free unchanged. Release id 7 with NUM_TAGS=4 -> ignored.
- Reset asserted while gen_req=1 -> gen_req=0 asynchronously, no ack pulse, tags_free=4. With TX_RD_ARB_STATS_EN, stat counters read 0.
